// File: rtl/xor_shift_pkg.sv
// Shared types, S-box table and rotate helper for the xor-shift engine.
// Used by xor_shift_engine and xor_shift_nibble.
package xor_shift_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } xs_state_t;

    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    localparam int ROT_MAX = 32;

    // Rotate the low 'width' bits of value left by 'amount' (modulo width).
    function automatic logic [ROT_MAX-1:0] rotl(input logic [ROT_MAX-1:0] value,
                                                input int unsigned width,
                                                input int unsigned amount);
        logic [ROT_MAX-1:0] mask;
        logic [ROT_MAX-1:0] v;
        int unsigned a;
        mask = (ROT_MAX'(1) << width) - ROT_MAX'(1);
        v    = value & mask;
        a    = amount % width;
        if (a == 0) begin
            rotl = v;
        end else begin
            rotl = ((v << a) | (v >> (width - a))) & mask;
        end
    endfunction

endpackage

// File: rtl/xor_shift_nibble.sv
// Combinational single-nibble step: result = rotl(operand ^ s, amt) within NIB_W bits.
module xor_shift_nibble
    import xor_shift_pkg::*;
#(
    parameter int NIB_W = 4,
    parameter int AMT_W = (NIB_W > 1) ? $clog2(NIB_W) : 1
) (
    input  logic [NIB_W-1:0] operand,
    input  logic [NIB_W-1:0] s,
    input  logic [AMT_W-1:0] amt,
    output logic [NIB_W-1:0] result
);

    logic [ROT_MAX-1:0] rotated;

    assign rotated = rotl(ROT_MAX'(operand ^ s), NIB_W, 32'(amt));
    assign result  = rotated[NIB_W-1:0];

endmodule

// File: rtl/xor_shift_engine.sv
// In-place sequential xor-shift over a hash state word, one nibble per cycle.
// Optional macro XOR_SHIFT_SBOX_EN passes in_s through the 4-bit S-box before latching.
module xor_shift_engine
    import xor_shift_pkg::*;
#(
    parameter int NIB_W   = 4,
    parameter int NUM_NIB = 8,
    parameter int ROUNDS  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_NIB*NIB_W-1:0] in_h,
    input  logic [NIB_W-1:0]         in_s,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_NIB*NIB_W-1:0] out_h,
    output logic                     busy
);

    localparam int HW    = NUM_NIB * NIB_W;
    localparam int IDX_W = $clog2(NUM_NIB);
    localparam int RND_W = $clog2(ROUNDS + 1);
    localparam int AMT_W = (NIB_W > 1) ? $clog2(NIB_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_NIB - 1);
    localparam logic [RND_W-1:0] RND_LAST = RND_W'(ROUNDS - 1);

    xs_state_t          state_reg, state_next;
    logic [HW-1:0]      h_reg, h_next;
    logic [NIB_W-1:0]   s_reg, s_next;
    logic [IDX_W-1:0]   idx_reg, idx_succ;
    logic [RND_W-1:0]   rnd_reg;
    logic [NIB_W-1:0]   nib [NUM_NIB];
    logic [NIB_W-1:0]   operand, result;
    logic [AMT_W-1:0]   amt;
    logic               accept, last_step;

    assign accept    = (state_reg == IDLE) && in_valid;
    assign last_step = (state_reg == RUN) && (idx_reg == IDX_LAST) && (rnd_reg == RND_LAST);
    assign idx_succ  = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
    // At the last index the operand is nibble 0, already rewritten earlier this round.
    assign operand   = nib[idx_succ];
    assign amt       = AMT_W'((32'(idx_reg) >> 1) % 32'(NIB_W));

`ifdef XOR_SHIFT_SBOX_EN
    if (NIB_W != 4) begin : g_sbox_width_check
        $error("XOR_SHIFT_SBOX_EN requires NIB_W == 4");
    end
    assign s_next = NIB_W'(SBOX[in_s]);
`else
    assign s_next = in_s;
`endif

    xor_shift_nibble #(
        .NIB_W (NIB_W),
        .AMT_W (AMT_W)
    ) u_nibble (
        .operand (operand),
        .s       (s_reg),
        .amt     (amt),
        .result  (result)
    );

    for (genvar gi = 0; gi < NUM_NIB; gi++) begin : g_nib
        assign nib[gi] = h_reg[gi*NIB_W +: NIB_W];
        assign h_next[gi*NIB_W +: NIB_W] = (idx_reg == IDX_W'(gi)) ? result : nib[gi];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_reg   <= '0;
            s_reg   <= '0;
            idx_reg <= '0;
            rnd_reg <= '0;
        end else if (accept) begin
            h_reg   <= in_h;
            s_reg   <= s_next;
            idx_reg <= '0;
            rnd_reg <= '0;
        end else if (state_reg == RUN) begin
            h_reg   <= h_next;
            idx_reg <= idx_succ;
            if (idx_reg == IDX_LAST) begin
                rnd_reg <= rnd_reg + 1'b1;
            end
        end
    end

    assign out_h     = h_reg;
    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg == RUN);

endmodule

// File: tb/tb_xor_shift_engine.sv
// Directed bench for xor_shift_engine: default instance plus a ROUNDS=2 instance.
// Stimulus nibbles are chosen so expectations hold with or without XOR_SHIFT_SBOX_EN.
module tb_xor_shift_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [31:0] in_h, out_h;
    logic [3:0]  in_s;

    logic        in_valid_2, in_ready_2, out_valid_2, out_ready_2, busy_2;
    logic [31:0] in_h_2, out_h_2;
    logic [3:0]  in_s_2;

    int n_vec = 0;
    int n_err = 0;

`ifdef XOR_SHIFT_SBOX_EN
    localparam logic [3:0]  S_1    = 4'hE;
    localparam logic [3:0]  S_F    = 4'hA;
    localparam logic [3:0]  S_0    = 4'h5;
    localparam logic [31:0] EXP_S5 = 32'h0000_0000;
`else
    localparam logic [3:0]  S_1    = 4'h1;
    localparam logic [3:0]  S_F    = 4'hF;
    localparam logic [3:0]  S_0    = 4'h0;
    localparam logic [31:0] EXP_S5 = 32'h0A55_AA55;
`endif

    always #5 clk = ~clk;

    xor_shift_engine dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_h      (in_h),
        .in_s      (in_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_h     (out_h),
        .busy      (busy)
    );

    xor_shift_engine #(.NIB_W(4), .NUM_NIB(8), .ROUNDS(2)) dut_2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_2),
        .in_ready  (in_ready_2),
        .in_h      (in_h_2),
        .in_s      (in_s_2),
        .out_valid (out_valid_2),
        .out_ready (out_ready_2),
        .out_h     (out_h_2),
        .busy      (busy_2)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic run_job(input string tag, input logic [31:0] h, input logic [3:0] s,
                           input logic [31:0] exp);
        int lat;
        @(negedge clk);
        check_val({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
        in_h = h;
        in_s = s;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        check_val({tag, " busy run"}, 32'(busy), 32'd1);
        check_val({tag, " in_ready run"}, 32'(in_ready), 32'd0);
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check_val({tag, " latency"}, 32'(lat), 32'd9);
        check_val({tag, " out_h"}, out_h, exp);
        check_val({tag, " busy done"}, 32'(busy), 32'd0);
        $display("job %s: in_h=%h in_s=%h -> out_h=%h latency=%0d", tag, h, s, out_h, lat);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_val({tag, " in_ready after"}, 32'(in_ready), 32'd1);
        check_val({tag, " out_valid after"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int lat;
        in_valid = 1'b0; out_ready = 1'b0; in_h = '0; in_s = '0;
        in_valid_2 = 1'b0; out_ready_2 = 1'b0; in_h_2 = '0; in_s_2 = '0;

        repeat (3) @(negedge clk);
        check_val("reset out_h", out_h, 32'h0);
        check_val("reset out_valid", 32'(out_valid), 32'd0);
        check_val("reset busy", 32'(busy), 32'd0);
        check_val("reset in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        run_job("zero_s1", 32'h0000_0000, S_1, 32'h0844_2211);
        run_job("zero_sF", 32'h0000_0000, S_F, 32'h0FFF_FFFF);
        run_job("ones_s0", 32'hFFFF_FFFF, S_0, 32'hFFFF_FFFF);
        run_job("mixed_s0", 32'h1234_5678, S_0, 32'hB88C_8A67);
        run_job("raw_s5", 32'h0000_0000, 4'h5, EXP_S5);

        // Back-pressure: hold the result while a second job is offered.
        @(negedge clk);
        in_h = 32'h0; in_s = S_1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check_val("hold latency", 32'(lat), 32'd9);
        in_h = 32'hFFFF_FFFF; in_s = S_F; in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_val("hold out_valid", 32'(out_valid), 32'd1);
            check_val("hold out_h", out_h, 32'h0844_2211);
            check_val("hold in_ready", 32'(in_ready), 32'd0);
        end
        $display("job hold: out_h=%h held 20 cycles with extra in_valid", out_h);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b0;
        check_val("hold release in_ready", 32'(in_ready), 32'd1);
        check_val("hold release out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check_val("hold no stray job", 32'(busy), 32'd0);

        // Abort mid-RUN with reset.
        in_h = 32'h1234_5678; in_s = S_F; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_val("abort busy before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check_val("abort out_valid", 32'(out_valid), 32'd0);
        check_val("abort out_h", out_h, 32'h0);
        check_val("abort busy", 32'(busy), 32'd0);
        check_val("abort in_ready", 32'(in_ready), 32'd1);
        $display("job abort: reset in RUN cycle 4, out_h=%h", out_h);
        @(negedge clk);
        rst = 1'b0;
        run_job("after_abort", 32'h0000_0000, S_1, 32'h0844_2211);

        // Two-round instance.
        @(negedge clk);
        check_val("r2 in_ready", 32'(in_ready_2), 32'd1);
        in_h_2 = 32'h0; in_s_2 = S_1; in_valid_2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_2 = 1'b0;
        lat = 1;
        while (!out_valid_2 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check_val("r2 latency", 32'(lat), 32'd17);
        check_val("r2 out_h", out_h_2, 32'h8865_A630);
        $display("job rounds2: in_h=%h -> out_h=%h latency=%0d", 32'h0, out_h_2, lat);
        out_ready_2 = 1'b1;
        @(negedge clk);
        out_ready_2 = 1'b0;
        check_val("r2 in_ready after", 32'(in_ready_2), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/xor_shift_engine.md
# xor_shift_engine

Sequential, parametrised successor to the single-nibble xor-shift step of the HES compression function. Accepts a full hash state word and a substitution nibble over a valid/ready handshake. Applies H[i] = rotl(H[(i+1) mod N] ^ S, floor(i/2) mod W) to every nibble, in place, one nibble per cycle, for a configurable number of rounds. Returns the result over a second valid/ready handshake. Sits between the message-schedule S-box stage and the state register of the hash core.

## Interface
- NIB_W, 4: nibble width W in bits (≥2)
- NUM_NIB, 8: nibbles per state word N (≥2)
- ROUNDS, 1: full passes over the state per job (≥1)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  job offered
- in_ready  out  1  engine can accept a job
- in_h  in  NUM_NIB*NIB_W  initial state; nibble i at bits [i*W +: W]
- in_s  in  NIB_W  substitution nibble S (or raw message nibble, see Configuration)
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_h  out  NUM_NIB*NIB_W  final state
- busy  out  1  high while in RUN

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE. After reset: out_h=0, out_valid=0, busy=0, in_ready=1.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - latch in_h into the state register and in_s into the S register;
  - clear the nibble index idx and the round counter rnd;
  - go to RUN.
- RUN: in_ready=0, busy=1. Each cycle, write nibble idx.
  - Operand is the current register nibble (idx+1) mod N. Sequential, in place: at idx=N-1 the operand is nibble 0 already updated in this round.
  - New value = rotl(operand ^ S, floor(idx/2) mod W). Rotation within W bits. Amount 0 leaves the value unchanged.
  - idx increments; wrap N-1→0 increments rnd.
  - When idx=N-1 and rnd=ROUNDS-1, go to DONE.
- DONE: out_valid=1. out_h holds the final state, stable until handshake. On out_ready, go to IDLE.
- out_ready while not in DONE is ignored. in_valid outside IDLE is ignored; upstream holds it.
- rst asserted in any state, including mid-RUN: job aborts, all registers clear immediately, no partial result is emitted.
- Counter widths: idx is $clog2(NUM_NIB), rnd is $clog2(ROUNDS+1). No arithmetic overflow beyond the W-bit nibble.

## Timing
- Accept edge to out_valid: exactly NUM_NIB*ROUNDS+1 cycles (8+1=9 for defaults).
- out_valid rises the cycle after the last nibble write.
- Output handshake edge → in_ready=1 the next cycle. No back-to-back acceptance in the same cycle as result delivery.
- Throughput: one job per NUM_NIB*ROUNDS+2 cycles when out_ready is held high.
- All outputs are registered or decoded from state only. No combinational path from in_* or out_ready to any output.

## Configuration
- Macro XOR_SHIFT_SBOX_EN.
- Defined: in_s is a raw message nibble; the latched S = SBOX(in_s) using the 4-bit table 0..F → C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2. Requires NIB_W=4; elaboration-time error otherwise. The S-box sits on the latch path; latency is unchanged.
- Undefined: in_s is used directly as S for any NIB_W.

## Structure
- Package xor_shift_pkg holds:
  - state enum xs_state_t (IDLE, RUN, DONE);
  - the SBOX constant array;
  - a rotl function parametrised by width.
- One sub-module: xor_shift_nibble. Purely combinational, it computes rotl(operand ^ S, amt) for one nibble. The engine instantiates it once and muxes the operand and target by idx.

## Test plan
- Defaults, no macro. in_h=32'h0000_0000, in_s=4'h1 → out_h=32'h0844_2211, out_valid exactly 9 cycles after accept.
- in_h=32'h0000_0000, in_s=4'hF → out_h=32'h0FFF_FFFF (nibble 7 reads updated nibble 0 = F, F^F=0).
- in_h=32'hFFFF_FFFF, in_s=4'h0 → out_h=32'hFFFF_FFFF.
- out_ready held low 20 cycles in DONE → out_h and out_valid stable, in_ready=0, second in_valid ignored. Release → handshake, in_ready=1 the next cycle.
- rst pulsed at RUN cycle 4 → out_valid=0, out_h=0, busy=0, in_ready=1 the same cycle. A subsequent job yields the correct result.
- XOR_SHIFT_SBOX_EN defined, in_h=0, in_s=4'h5 (SBOX→0) → out_h=32'h0000_0000. Also ROUNDS=2 with in_s=4'h1 → out_valid after 17 cycles.
